pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage CPU pipeline. It drives the ClockEnable and bubble (flush) controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard classes with fixed priority: multi-cycle data-memory waits, taken branches and load-use dependencies. It also provides halt/resume, a memory-timeout fault state and a saturating stall-cycle counter for debug.

---
 rtl/pipeline_ctrl_pkg.sv | 17 +
 rtl/load_use_detect.sv | 28 ++
 rtl/pipeline_stall_controller.sv | 145 ++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and its helpers.
//   state_t        : controller state encoding (RUN, MEM_WAIT, HALTED, FAULT)
//   COUNT_BITS_DEF : default width of the debug stall-cycle counter
//   ZERO_REG       : index of the hard-wired zero register (never a real dependency)
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam int COUNT_BITS_DEF = 16;
  localparam int ZERO_REG       = 0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the instruction in ID and a
// load in EX. Shared with the forwarding unit.
//   rs1, rs2           : ID source register indices
//   uses_rs1, uses_rs2 : the source is actually read
//   rd, mem_read       : EX destination index, EX instruction is a load
//   lu                 : ID must wait one cycle for the load result
module load_use_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int RegAddrBits = 5
) (
  input  logic [RegAddrBits-1:0] rs1,
  input  logic [RegAddrBits-1:0] rs2,
  input  logic                   uses_rs1,
  input  logic                   uses_rs2,
  input  logic [RegAddrBits-1:0] rd,
  input  logic                   mem_read,
  output logic                   lu
);

  // Writes to the zero register are discarded, so they never create a hazard.
  logic rd_live;
  assign rd_live = (rd != RegAddrBits'(ZERO_REG));

  assign lu = mem_read & rd_live &
              ((uses_rs1 & (rs1 == rd)) | (uses_rs2 & (rs2 == rd)));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Resolves, in priority order, data-memory waits, halt, taken branches and
// load-use hazards; drives register enables and bubble controls combinationally.
//   Clock, Reset (async low), Tick (global advance qualifier)
//   ID_*/EX_*/MEM_* : hazard sources; Halt/Resume : debug halt control
//   *_En, *_Flush   : pipeline register enables and bubble loads
//   State, MemTimeoutErr, StallCount : status / debug
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int RegAddrBits = 5,
  parameter int MemTimeout  = 255,
  parameter int CountBits   = COUNT_BITS_DEF
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Tick,
  input  logic [RegAddrBits-1:0] ID_Rs1,
  input  logic [RegAddrBits-1:0] ID_Rs2,
  input  logic                   ID_UsesRs1,
  input  logic                   ID_UsesRs2,
  input  logic [RegAddrBits-1:0] EX_Rd,
  input  logic                   EX_MemRead,
  input  logic                   EX_BranchTaken,
  input  logic                   MEM_Req,
  input  logic                   MEM_Ready,
  input  logic                   Halt,
  input  logic                   Resume,
  output logic                   PC_En,
  output logic                   IF_ID_En,
  output logic                   ID_EX_En,
  output logic                   EX_MEM_En,
  output logic                   MEM_WB_En,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Flush,
  output logic [1:0]             State,
  output logic                   MemTimeoutErr,
  output logic [CountBits-1:0]   StallCount
);

  state_t         state, state_nxt;
  logic [15:0]    wait_cnt, wait_nxt;
  logic [CountBits-1:0] stall_cnt;

  logic lu, ms, timeout_hit, count_en;
  // en order: {PC, IF/ID, ID/EX, EX/MEM, MEM/WB}
  logic [4:0] run_en, en;
  logic       run_fl_ifid, run_fl_idex, fl_ifid, fl_idex;

  load_use_detect #(.RegAddrBits(RegAddrBits)) u_lu (
    .rs1      (ID_Rs1),
    .rs2      (ID_Rs2),
    .uses_rs1 (ID_UsesRs1),
    .uses_rs2 (ID_UsesRs2),
    .rd       (EX_Rd),
    .mem_read (EX_MemRead),
    .lu       (lu)
  );

  assign ms = MEM_Req & ~MEM_Ready;

  // The RUN entry cycle counts as wait cycle 1, so the counter (cleared on
  // entry) trails the elapsed wait by one: fault on the Tick where the
  // incremented count reaches MemTimeout-1.
  assign timeout_hit = ({1'b0, wait_cnt} + 17'd2) >= 17'(MemTimeout);

  // Branch/load-use decode shared by RUN and the MEM_WAIT completion cycle.
  always_comb begin
    run_en      = 5'b11111;
    run_fl_ifid = 1'b0;
    run_fl_idex = 1'b0;
    if (EX_BranchTaken) begin
      run_fl_ifid = 1'b1;
      run_fl_idex = 1'b1;
    end else if (lu) begin
      run_en      = 5'b00111;
      run_fl_idex = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    en        = 5'b00000;
    fl_ifid   = 1'b0;
    fl_idex   = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (ms) begin
          state_nxt = ST_MEM_WAIT;
          wait_nxt  = '0;
        end else if (Halt) begin
          state_nxt = ST_HALTED;
        end else begin
          en      = run_en;
          fl_ifid = run_fl_ifid;
          fl_idex = run_fl_idex;
        end
      end
      ST_MEM_WAIT: begin
        if (!MEM_Ready) begin
          wait_nxt = wait_cnt + 16'd1;
          if (timeout_hit) state_nxt = ST_FAULT;
        end else begin
          // Halt is deliberately ignored on the completion cycle.
          en        = run_en;
          fl_ifid   = run_fl_ifid;
          fl_idex   = run_fl_idex;
          state_nxt = ST_RUN;
        end
      end
      ST_HALTED: if (Resume) state_nxt = ST_RUN;
      ST_FAULT:  ;
      default:   state_nxt = ST_RUN;
    endcase
    if (!(Tick && Reset)) begin
      en      = 5'b00000;
      fl_ifid = 1'b0;
      fl_idex = 1'b0;
    end
  end

  assign {PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En} = en;
  assign IF_ID_Flush   = fl_ifid;
  assign ID_EX_Flush   = fl_idex;
  assign State         = state;
  assign MemTimeoutErr = (state == ST_FAULT);
  assign StallCount    = stall_cnt;

  assign count_en = ((state == ST_RUN) || (state == ST_MEM_WAIT)) &&
                    !PC_En && (stall_cnt != '1);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else if (Tick) begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (count_en) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

  logic       Clock, Reset, Tick;
  logic [4:0] ID_Rs1, ID_Rs2, EX_Rd;
  logic       ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_BranchTaken;
  logic       MEM_Req, MEM_Ready, Halt, Resume;
  logic       PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En;
  logic       IF_ID_Flush, ID_EX_Flush, MemTimeoutErr;
  logic [1:0] State;
  logic [15:0] StallCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [4:0]  en;
    logic [1:0]  fl;
    logic [1:0]  st;
    logic        err;
    logic [15:0] sc;
  } exp_t;

  exp_t sb[$];

  pipeline_stall_controller #(.RegAddrBits(5), .MemTimeout(4), .CountBits(16)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick),
    .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
    .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead), .EX_BranchTaken(EX_BranchTaken),
    .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready), .Halt(Halt), .Resume(Resume),
    .PC_En(PC_En), .IF_ID_En(IF_ID_En), .ID_EX_En(ID_EX_En),
    .EX_MEM_En(EX_MEM_En), .MEM_WB_En(MEM_WB_En),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .State(State), .MemTimeoutErr(MemTimeoutErr), .StallCount(StallCount)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [4:0] en, input logic [1:0] fl,
                      input logic [1:0] st, input logic err, input logic [15:0] sc);
    exp_t e;
    e.tag = tag; e.en = en; e.fl = fl; e.st = st; e.err = err; e.sc = sc;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the live outputs.
  task automatic pop_check();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_en"}, 32'({PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En}), 32'(e.en));
      chk({e.tag, "_flush"}, 32'({IF_ID_Flush, ID_EX_Flush}), 32'(e.fl));
      chk({e.tag, "_state"}, 32'(State), 32'(e.st));
      chk({e.tag, "_err"}, 32'(MemTimeoutErr), 32'(e.err));
      chk({e.tag, "_stallcnt"}, 32'(StallCount), 32'(e.sc));
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1 time unit
  // later, well clear of the next rising edge.
  task automatic step(input string tag, input logic [4:0] en, input logic [1:0] fl,
                      input logic [1:0] st, input logic err, input logic [15:0] sc);
    push(tag, en, fl, st, err, sc);
    #1;
    pop_check();
    @(negedge Clock);
  endtask

  task automatic clear_in();
    ID_Rs1 = 5'd0; ID_Rs2 = 5'd0; ID_UsesRs1 = 1'b0; ID_UsesRs2 = 1'b0;
    EX_Rd = 5'd0; EX_MemRead = 1'b0; EX_BranchTaken = 1'b0;
    MEM_Req = 1'b0; MEM_Ready = 1'b0; Halt = 1'b0; Resume = 1'b0;
  endtask

  initial begin
    clear_in();
    Reset = 1'b0;
    Tick  = 1'b1;
    @(negedge Clock);
    step("reset", 5'b00000, 2'b00, 2'd0, 1'b0, 16'd0);

    Reset = 1'b1;
    step("run_idle", 5'b11111, 2'b00, 2'd0, 1'b0, 16'd0);

    // Load-use on rs2.
    EX_MemRead = 1'b1; EX_Rd = 5'd5; ID_Rs2 = 5'd5; ID_UsesRs2 = 1'b1;
    step("load_use", 5'b00111, 2'b01, 2'd0, 1'b0, 16'd0);
    // Branch overrides load-use; StallCount shows the previous stall.
    EX_BranchTaken = 1'b1;
    step("branch_lu", 5'b11111, 2'b11, 2'd0, 1'b0, 16'd1);
    EX_BranchTaken = 1'b0;
    // Source not actually read: no hazard.
    ID_UsesRs2 = 1'b0;
    step("lu_unused", 5'b11111, 2'b00, 2'd0, 1'b0, 16'd1);
    // Destination x0 never stalls.
    ID_UsesRs2 = 1'b1; EX_Rd = 5'd0; ID_Rs2 = 5'd0;
    step("lu_x0", 5'b11111, 2'b00, 2'd0, 1'b0, 16'd1);
    // Load-use through rs1.
    EX_Rd = 5'd9; ID_Rs1 = 5'd9; ID_UsesRs1 = 1'b1; ID_UsesRs2 = 1'b0;
    step("lu_rs1", 5'b00111, 2'b01, 2'd0, 1'b0, 16'd1);
    clear_in();

    // Memory wait: 3 frozen Tick cycles then completion.
    MEM_Req = 1'b1;
    step("mw_enter", 5'b00000, 2'b00, 2'd0, 1'b0, 16'd2);
    Tick = 1'b0;
    step("mw_notick", 5'b00000, 2'b00, 2'd1, 1'b0, 16'd3);
    Tick = 1'b1;
    step("mw_wait2", 5'b00000, 2'b00, 2'd1, 1'b0, 16'd3);
    step("mw_wait3", 5'b00000, 2'b00, 2'd1, 1'b0, 16'd4);
    MEM_Ready = 1'b1; Halt = 1'b1;
    step("mw_done", 5'b11111, 2'b00, 2'd1, 1'b0, 16'd5);
    MEM_Req = 1'b0; Halt = 1'b0;
    step("ready_noreq", 5'b11111, 2'b00, 2'd0, 1'b0, 16'd5);
    MEM_Ready = 1'b0;

    // Timeout: MemTimeout=4 Ticks of MS including the RUN entry cycle.
    MEM_Req = 1'b1;
    step("to_c1", 5'b00000, 2'b00, 2'd0, 1'b0, 16'd5);
    step("to_c2", 5'b00000, 2'b00, 2'd1, 1'b0, 16'd6);
    step("to_c3", 5'b00000, 2'b00, 2'd1, 1'b0, 16'd7);
    step("to_c4", 5'b00000, 2'b00, 2'd1, 1'b0, 16'd8);
    step("fault", 5'b00000, 2'b00, 2'd3, 1'b1, 16'd9);
    MEM_Req = 1'b0; MEM_Ready = 1'b1; Resume = 1'b1;
    step("fault_hold", 5'b00000, 2'b00, 2'd3, 1'b1, 16'd9);
    clear_in();
    Reset = 1'b0;
    step("fault_reset", 5'b00000, 2'b00, 2'd0, 1'b0, 16'd0);
    Reset = 1'b1;
    step("post_fault", 5'b11111, 2'b00, 2'd0, 1'b0, 16'd0);

    // Reset in the middle of a memory wait aborts it.
    MEM_Req = 1'b1;
    step("mw2_enter", 5'b00000, 2'b00, 2'd0, 1'b0, 16'd0);
    step("mw2_wait", 5'b00000, 2'b00, 2'd1, 1'b0, 16'd1);
    Reset = 1'b0;
    step("mw2_reset", 5'b00000, 2'b00, 2'd0, 1'b0, 16'd0);
    Reset = 1'b1; MEM_Req = 1'b0;
    step("mw2_after", 5'b11111, 2'b00, 2'd0, 1'b0, 16'd0);

    // Halt / resume; the halt-entry cycle in RUN is a stall cycle.
    Halt = 1'b1;
    step("halt_req", 5'b00000, 2'b00, 2'd0, 1'b0, 16'd0);
    step("halted", 5'b00000, 2'b00, 2'd2, 1'b0, 16'd1);
    Tick = 1'b0; Resume = 1'b1;
    step("halt_notick", 5'b00000, 2'b00, 2'd2, 1'b0, 16'd1);
    Tick = 1'b1;
    step("resume", 5'b00000, 2'b00, 2'd2, 1'b0, 16'd1);
    Halt = 1'b0; Resume = 1'b0;
    step("resumed", 5'b11111, 2'b00, 2'd0, 1'b0, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
